// File: rtl/regfile_write_arbiter.sv
// Sole owner of the register-file write port: zero-fills X0..X30 after reset,
// then round-robin arbitrates ALU (A) and load (B) writebacks with 1-cycle registered writes.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 31
) (
  input  logic                  Clk,
  input  logic                  ResetL,
  input  logic                  ValidA,
  input  logic [ADDR_WIDTH-1:0] AddrA,
  input  logic [DATA_WIDTH-1:0] DataA,
  output logic                  ReadyA,
  input  logic                  ValidB,
  input  logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic                  ReadyB,
  output logic [ADDR_WIDTH-1:0] RW,
  output logic [DATA_WIDTH-1:0] BusW,
  output logic                  RegWr,
  output logic                  InitDone
);

  typedef enum logic {S_INIT, S_ARB} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_INIT = ADDR_WIDTH'(NUM_REGS - 2);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = ADDR_WIDTH'(ZERO_REG);

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  favor_b;  // 1 when A was granted last

  assign InitDone = (state == S_ARB);

  always_comb begin
    ReadyA = 1'b0;
    ReadyB = 1'b0;
    if (state == S_ARB) begin
      ReadyA = ValidA && (!ValidB || !favor_b);
      ReadyB = ValidB && (!ValidA ||  favor_b);
    end
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      state    <= S_INIT;
      init_cnt <= '0;
      favor_b  <= 1'b0;
      RW       <= '0;
      BusW     <= '0;
      RegWr    <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          // Leave only after the X30 write has actually been presented on the port.
          if (RegWr && RW == LAST_INIT) begin
            state <= S_ARB;
            RegWr <= 1'b0;
          end else begin
            RW    <= init_cnt;
            BusW  <= '0;
            RegWr <= 1'b1;
            if (init_cnt != LAST_INIT) init_cnt <= init_cnt + ADDR_WIDTH'(1);
          end
        end
        S_ARB: begin
          // Pointer tracks the last granted requester, whether or not the other was contending.
          if (ReadyA) begin
            RW      <= AddrA;
            BusW    <= DataA;
            RegWr   <= (AddrA != ZERO_IDX);
            favor_b <= 1'b1;
          end else if (ReadyB) begin
            RW      <= AddrB;
            BusW    <= DataB;
            RegWr   <= (AddrB != ZERO_IDX);
            favor_b <= 1'b0;
          end else begin
            RegWr   <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: zero-fill, arbitration order, ZERO_REG suppression, async reset.
module tb_regfile_write_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          valid_a, valid_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic          ready_a, ready_b;
  logic [AW-1:0] rw;
  logic [DW-1:0] bus_w;
  logic          reg_wr, init_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] rf [32];

  regfile_write_arbiter dut (
    .Clk(clk), .ResetL(rst_l),
    .ValidA(valid_a), .AddrA(addr_a), .DataA(data_a), .ReadyA(ready_a),
    .ValidB(valid_b), .AddrB(addr_b), .DataB(data_b), .ReadyB(ready_b),
    .RW(rw), .BusW(bus_w), .RegWr(reg_wr), .InitDone(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_wr) rf[rw] <= bus_w;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0; valid_a = 1'b1; valid_b = 1'b1;
    addr_a = 5'd5; data_a = 64'h1234; addr_b = '0; data_b = '0;
    #3;
    n_checks++;
    if (reg_wr !== 1'b0 || init_done !== 1'b0 || rw !== 5'd0 || bus_w !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: RegWr=%b InitDone=%b RW=%0d BusW=%h, required 0 0 0 0", reg_wr, init_done, rw, bus_w);
    end
    n_checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: ReadyA=%b ReadyB=%b, required 0 0", ready_a, ready_b);
    end
    valid_b = 1'b0;
  endtask

  // ValidA held through INIT: 31 zero writes, no grant, then AddrA=5 accepted on first ARB cycle.
  task automatic test_init_then_first_grant();
    @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick();
      n_checks++;
      if (reg_wr !== 1'b1 || rw !== AW'(i) || bus_w !== 64'd0 || ready_a !== 1'b0 || init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL init_cycle_%0d: RegWr=%b RW=%0d BusW=%h ReadyA=%b InitDone=%b, required 1 %0d 0 0 0",
                 i, reg_wr, rw, bus_w, ready_a, init_done, i);
      end
    end
    tick();
    n_checks++;
    if (reg_wr !== 1'b0 || init_done !== 1'b1 || ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL first_arb_cycle: RegWr=%b InitDone=%b ReadyA=%b, required 0 1 1", reg_wr, init_done, ready_a);
    end
    tick();
    valid_a = 1'b0;
    n_checks++;
    if (rw !== 5'd5 || bus_w !== 64'h1234 || reg_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL first_write: RW=%0d BusW=%h RegWr=%b, required 5 1234 1", rw, bus_w, reg_wr);
    end
  endtask

  // A single B grant leaves A favoured, then dual requests alternate A,B,A,B.
  task automatic test_alternate();
    valid_b = 1'b1; addr_b = 5'd3; data_b = 64'h33;
    #1;
    n_checks++;
    if (ready_b !== 1'b1 || ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_b_ready: ReadyA=%b ReadyB=%b, required 0 1", ready_a, ready_b);
    end
    tick();
    valid_b = 1'b0;
    n_checks++;
    if (rw !== 5'd3 || bus_w !== 64'h33 || reg_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL single_b_write: RW=%0d BusW=%h RegWr=%b, required 3 33 1", rw, bus_w, reg_wr);
    end
    valid_a = 1'b1; addr_a = 5'd1; data_a = 64'hA;
    valid_b = 1'b1; addr_b = 5'd2; data_b = 64'hB;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (ready_a !== (k % 2 == 0) || ready_b !== (k % 2 == 1)) begin
        n_fail++;
        $display("FAIL alt_grant_%0d: ReadyA=%b ReadyB=%b, required %0d %0d", k, ready_a, ready_b, k % 2 == 0, k % 2 == 1);
      end
      tick();
      n_checks++;
      if (rw !== ((k % 2 == 0) ? 5'd1 : 5'd2) || bus_w !== ((k % 2 == 0) ? 64'hA : 64'hB) || reg_wr !== 1'b1) begin
        n_fail++;
        $display("FAIL alt_write_%0d: RW=%0d BusW=%h RegWr=%b, required %0d %h 1",
                 k, rw, bus_w, reg_wr, (k % 2 == 0) ? 1 : 2, (k % 2 == 0) ? 64'hA : 64'hB);
      end
    end
    valid_a = 1'b0; valid_b = 1'b0;
  endtask

  task automatic test_zero_reg();
    valid_b = 1'b1; addr_b = 5'd31; data_b = 64'hFFFF;
    #1;
    n_checks++;
    if (ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_b_ready: ReadyB=%b, required 1", ready_b);
    end
    tick();
    valid_b = 1'b0;
    n_checks++;
    if (reg_wr !== 1'b0 || rw !== 5'd31 || bus_w !== 64'hFFFF) begin
      n_fail++;
      $display("FAIL zero_b_write: RegWr=%b RW=%0d BusW=%h, required 0 31 ffff", reg_wr, rw, bus_w);
    end
    valid_a = 1'b1; addr_a = 5'd31; data_a = 64'h5555;
    #1;
    n_checks++;
    if (ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_a_ready: ReadyA=%b, required 1", ready_a);
    end
    tick();
    valid_a = 1'b0;
    n_checks++;
    if (reg_wr !== 1'b0 || rw !== 5'd31 || bus_w !== 64'h5555) begin
      n_fail++;
      $display("FAIL zero_a_write: RegWr=%b RW=%0d BusW=%h, required 0 31 5555", reg_wr, rw, bus_w);
    end
  endtask

  // Last grant was A, so B wins the same-address conflict and A's data lands last.
  task automatic test_same_addr();
    valid_a = 1'b1; addr_a = 5'd10; data_a = 64'h1010;
    valid_b = 1'b1; addr_b = 5'd10; data_b = 64'h2020;
    #1;
    n_checks++;
    if (ready_b !== 1'b1 || ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_first_grant: ReadyA=%b ReadyB=%b, required 0 1", ready_a, ready_b);
    end
    tick();
    valid_b = 1'b0;
    n_checks++;
    if (rw !== 5'd10 || bus_w !== 64'h2020 || reg_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_write_b: RW=%0d BusW=%h RegWr=%b, required 10 2020 1", rw, bus_w, reg_wr);
    end
    #1;
    n_checks++;
    if (ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_second_grant: ReadyA=%b, required 1", ready_a);
    end
    tick();
    valid_a = 1'b0;
    n_checks++;
    if (rw !== 5'd10 || bus_w !== 64'h1010 || reg_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_write_a: RW=%0d BusW=%h RegWr=%b, required 10 1010 1", rw, bus_w, reg_wr);
    end
    tick();
    n_checks++;
    if (reg_wr !== 1'b0 || rw !== 5'd10 || bus_w !== 64'h1010) begin
      n_fail++;
      $display("FAIL idle_hold: RegWr=%b RW=%0d BusW=%h, required 0 10 1010", reg_wr, rw, bus_w);
    end
    n_checks++;
    if (rf[10] !== 64'h1010) begin
      n_fail++;
      $display("FAIL rf_x10: got %h, required 1010", rf[10]);
    end
  endtask

  task automatic test_reset_mid_arb();
    valid_a = 1'b1; addr_a = 5'd7; data_a = 64'h77;
    tick();
    valid_a = 1'b1;
    n_checks++;
    if (reg_wr !== 1'b1 || rw !== 5'd7) begin
      n_fail++;
      $display("FAIL pre_reset_write: RegWr=%b RW=%0d, required 1 7", reg_wr, rw);
    end
    #2;
    rst_l = 1'b0;
    #1;
    n_checks++;
    if (reg_wr !== 1'b0 || init_done !== 1'b0 || ready_a !== 1'b0 || rw !== 5'd0) begin
      n_fail++;
      $display("FAIL async_reset: RegWr=%b InitDone=%b ReadyA=%b RW=%0d, required 0 0 0 0", reg_wr, init_done, ready_a, rw);
    end
    valid_a = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (reg_wr !== 1'b1 || rw !== AW'(i) || bus_w !== 64'd0) begin
        n_fail++;
        $display("FAIL restart_init_%0d: RegWr=%b RW=%0d BusW=%h, required 1 %0d 0", i, reg_wr, rw, bus_w, i);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_then_first_grant();
    test_alternate();
    test_zero_reg();
    test_same_addr();
    test_reset_mid_arb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
